// File: rtl/vp_pkg.sv
// Shared video-pipeline types and constants.
// Luma weights, pixel widths and stage control bundle.
package vp_pkg;

  localparam int PIX_W  = 24;
  localparam int LUMA_W = 8;

  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

  localparam int SOBEL_LATENCY = 5;

  localparam logic [PIX_W-1:0] OVERLAY_COL = 24'hFF0000;
  localparam logic [PIX_W-1:0] EDGE_WHITE  = 24'hFFFFFF;
  localparam logic [PIX_W-1:0] EDGE_BLACK  = 24'h000000;

  typedef struct packed {
    logic vs;
    logic de;
    logic bdr;
  } ctl_t;

  function automatic logic [LUMA_W-1:0] rgb2y(
    input logic [PIX_W-1:0] p
  );
    logic [15:0] s;
    s = {8'd0, COEF_R} * {8'd0, p[23:16]}
      + {8'd0, COEF_G} * {8'd0, p[15:8]}
      + {8'd0, COEF_B} * {8'd0, p[7:0]};
    return s[15:8];
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of luma storage for the Sobel window.
// Single write port, registered read port, read-before-write.
module sobel_line_buffer #(
  parameter int DEPTH = 1280,
  parameter int W     = 8,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // RAM write and registered read; same-address read sees old data
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel edge detector, 5-cycle fixed latency.
// Define SOBEL_OVERLAY_EN to paint edges red over the source RGB.
module sobel_edge
  import vp_pkg::*;
#(
  parameter logic [11:0] IMG_HDISP = 12'd1280,
  parameter logic [11:0] IMG_VDISP = 12'd720
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EN,
  input  logic [7:0]        threshold,
  input  logic              pre_vs,
  input  logic              pre_de,
  input  logic [PIX_W-1:0]  pre_data,
  output logic              post_vs,
  output logic              post_de,
  output logic [PIX_W-1:0]  post_data
);

  localparam int AW =
    (IMG_HDISP > 12'd1) ? $clog2(int'(IMG_HDISP)) : 1;

  logic [11:0] x;
  logic [11:0] y;
  logic        vs_d;
  logic        de_d;
  logic        en_q;
  logic        de_in;
  logic        in_bdr;
  logic        x_ok;

  assign de_in  = pre_de & ~pre_vs;
  assign x_ok   = x < IMG_HDISP;
  assign in_bdr = (x < 12'd2) || (y < 12'd2)
                || !x_ok || !en_q;

  // frame position counters and per-frame enable latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      vs_d <= 1'b0;
      de_d <= 1'b0;
      en_q <= 1'b0;
    end else begin
      vs_d <= pre_vs;
      de_d <= de_in;
      if (pre_vs && !vs_d) en_q <= EN;
      if (pre_vs || !en_q) begin
        x <= '0;
        y <= '0;
      end else if (de_in) begin
        if (x_ok) x <= x + 12'd1;
      end else if (de_d) begin
        x <= '0;
        if (y < IMG_VDISP) y <= y + 12'd1;
      end
    end
  end

  logic [7:0]    s1_luma;
  logic [AW-1:0] s1_addr;
  logic          s1_we;
  ctl_t          s1_c;

  // S1: luma conversion and line-buffer address
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_luma <= '0;
      s1_addr <= '0;
      s1_we   <= 1'b0;
      s1_c    <= '0;
    end else begin
      s1_luma <= rgb2y(pre_data);
      s1_addr <= x_ok ? x[AW-1:0] : '0;
      s1_we   <= de_in && en_q && x_ok;
      s1_c    <= '{vs: pre_vs, de: pre_de, bdr: in_bdr};
    end
  end

  logic [7:0]    lb0_q;
  logic [7:0]    lb1_q;
  logic [AW-1:0] s2_addr;
  logic          s2_we;

  sobel_line_buffer #(
    .DEPTH (int'(IMG_HDISP)),
    .W     (8),
    .AW    (AW)
  ) u_lb0 (
    .clk   (clk),
    .we    (s1_we),
    .waddr (s1_addr),
    .wdata (s1_luma),
    .raddr (s1_addr),
    .rdata (lb0_q)
  );

  sobel_line_buffer #(
    .DEPTH (int'(IMG_HDISP)),
    .W     (8),
    .AW    (AW)
  ) u_lb1 (
    .clk   (clk),
    .we    (s2_we),
    .waddr (s2_addr),
    .wdata (lb0_q),
    .raddr (s1_addr),
    .rdata (lb1_q)
  );

  logic [7:0] p00, p01, p02;
  logic [7:0] p10, p11, p12;
  logic [7:0] p20, p21, p22;
  ctl_t       s2_c;

  assign p02 = lb1_q;
  assign p12 = lb0_q;

  // S2: window column shift; newest column comes from RAM ports
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p22     <= '0;
      p00     <= '0;
      p01     <= '0;
      p10     <= '0;
      p11     <= '0;
      p20     <= '0;
      p21     <= '0;
      s2_addr <= '0;
      s2_we   <= 1'b0;
      s2_c    <= '0;
    end else begin
      p22     <= s1_luma;
      p01     <= p02;
      p00     <= p01;
      p11     <= p12;
      p10     <= p11;
      p21     <= p22;
      p20     <= p21;
      s2_addr <= s1_addr;
      s2_we   <= s1_we;
      s2_c    <= s1_c;
    end
  end

  logic [9:0]         gx_p, gx_n;
  logic [9:0]         gy_p, gy_n;
  logic signed [10:0] gx, gy;
  logic signed [10:0] s3_gx, s3_gy;
  ctl_t               s3_c;

  assign gx_p = {2'b0, p02} + {1'b0, p12, 1'b0} + {2'b0, p22};
  assign gx_n = {2'b0, p00} + {1'b0, p10, 1'b0} + {2'b0, p20};
  assign gy_p = {2'b0, p20} + {1'b0, p21, 1'b0} + {2'b0, p22};
  assign gy_n = {2'b0, p00} + {1'b0, p01, 1'b0} + {2'b0, p02};
  assign gx = $signed({1'b0, gx_p}) - $signed({1'b0, gx_n});
  assign gy = $signed({1'b0, gy_p}) - $signed({1'b0, gy_n});

  // S3: signed gradients
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_gx <= '0;
      s3_gy <= '0;
      s3_c  <= '0;
    end else begin
      s3_gx <= gx;
      s3_gy <= gy;
      s3_c  <= s2_c;
    end
  end

  logic [10:0] gxu, gyu;
  logic [10:0] ax, ay;
  logic [10:0] s4_mag;
  ctl_t        s4_c;

  assign gxu = s3_gx;
  assign gyu = s3_gy;
  assign ax  = gxu[10] ? (~gxu + 11'd1) : gxu;
  assign ay  = gyu[10] ? (~gyu + 11'd1) : gyu;

  // S4: L1 gradient magnitude
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s4_mag <= '0;
      s4_c   <= '0;
    end else begin
      s4_mag <= ax + ay;
      s4_c   <= s3_c;
    end
  end

  logic             is_edge;
  logic [PIX_W-1:0] out_d;

  assign is_edge = (s4_mag > {3'b0, threshold}) && !s4_c.bdr;

`ifdef SOBEL_OVERLAY_EN
  logic [PIX_W-1:0] rgb_q [4];

  // source RGB delay matching S1..S4
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) rgb_q[i] <= '0;
    end else begin
      rgb_q[0] <= pre_data;
      for (int i = 1; i < 4; i++) rgb_q[i] <= rgb_q[i-1];
    end
  end

  // overlay pixel select
  always_comb begin
    out_d = EDGE_BLACK;
    if (s4_c.de) out_d = is_edge ? OVERLAY_COL : rgb_q[3];
  end
`else
  // binary pixel select
  always_comb begin
    out_d = EDGE_BLACK;
    if (s4_c.de && is_edge) out_d = EDGE_WHITE;
  end
`endif

  // S5: output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      post_vs   <= 1'b0;
      post_de   <= 1'b0;
      post_data <= '0;
    end else begin
      post_vs   <= s4_c.vs;
      post_de   <= s4_c.de;
      post_data <= out_d;
    end
  end

endmodule

// File: tb/tb_sobel_edge.sv
// Bench for sobel_edge: frame-level reference model and
// a 5-deep expected-output queue, directed plus random frames.
module tb_sobel_edge;

  localparam int HD = 8;
  localparam int VD = 6;
  localparam int LAT = 5;

`ifdef SOBEL_OVERLAY_EN
  localparam logic [23:0] EDGE_COL = 24'hFF0000;
  localparam bit OVL = 1'b1;
`else
  localparam logic [23:0] EDGE_COL = 24'hFFFFFF;
  localparam bit OVL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EN;
  logic [7:0]  threshold;
  logic        pre_vs;
  logic        pre_de;
  logic [23:0] pre_data;
  logic        post_vs;
  logic        post_de;
  logic [23:0] post_data;

  always #5 clk = ~clk;

  sobel_edge #(
    .IMG_HDISP (12'd8),
    .IMG_VDISP (12'd6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .EN        (EN),
    .threshold (threshold),
    .pre_vs    (pre_vs),
    .pre_de    (pre_de),
    .pre_data  (pre_data),
    .post_vs   (post_vs),
    .post_de   (post_de),
    .post_data (post_data)
  );

  typedef struct packed {
    logic        vs;
    logic        de;
    logic [23:0] d;
  } exp_t;

  logic [23:0] img [VD][HD];
  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   edges;
  int   thr_cur;
  bit   model_en;
  bit   prev_vs;

  function automatic int ly(input logic [23:0] p);
    return (77 * int'(p[23:16]) + 150 * int'(p[15:8])
          + 29 * int'(p[7:0])) / 256;
  endfunction

  function automatic logic [23:0] model_pix(input int r, input int c);
    logic [23:0] bg;
    int gx, gy, w;
    bg = OVL ? img[r][c] : 24'h0;
    if (!model_en || r < 2 || c < 2) return bg;
    gx = 0;
    gy = 0;
    for (int k = 0; k < 3; k++) begin
      w = (k == 1) ? 2 : 1;
      gx += w * (ly(img[r-2+k][c]) - ly(img[r-2+k][c-2]));
      gy += w * (ly(img[r][c-2+k]) - ly(img[r-2][c-2+k]));
    end
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return (gx + gy > thr_cur) ? EDGE_COL : bg;
  endfunction

  task automatic step(input logic vs, input logic de,
                      input int r, input int c, input logic rn);
    exp_t e;
    @(negedge clk);
    if (q.size() >= LAT) begin
      e = q.pop_front();
      checks += 3;
      assert (post_vs === e.vs) else begin
        failures++;
        $error("FAIL post_vs got=%b exp=%b", post_vs, e.vs);
      end
      assert (post_de === e.de) else begin
        failures++;
        $error("FAIL post_de got=%b exp=%b", post_de, e.de);
      end
      assert (post_data === e.d) else begin
        failures++;
        $error("FAIL post_data got=%h exp=%h", post_data, e.d);
      end
      if (post_de && post_data === EDGE_COL) edges++;
    end
    pre_vs   = vs;
    pre_de   = de;
    pre_data = de ? img[r][c] : 24'h0;
    rst_n    = rn;
    if (!rn) begin
      model_en = 1'b0;
      prev_vs  = 1'b0;
    end else begin
      if (vs && !prev_vs) model_en = EN;
      prev_vs = vs;
    end
    e.vs = vs;
    e.de = de;
    e.d  = de ? model_pix(r, c) : 24'h0;
    q.push_back(e);
    if (!rn)
      for (int i = 0; i < q.size(); i++) q[i] = '0;
  endtask

  task automatic run_frame(input int thr, input bit en0,
                           input int en_row, input bit en1,
                           input int rst_row, input int exp_edges);
    threshold = 8'(thr);
    thr_cur   = thr;
    EN        = en0;
    edges     = 0;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1);
    for (int r = 0; r < VD; r++) begin
      for (int c = 0; c < HD; c++) begin
        if (r == en_row && c == 0) EN = en1;
        step(0, 1, r, c, !(r == rst_row && c == 3));
      end
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    if (exp_edges >= 0) begin
      checks++;
      assert (edges == exp_edges) else begin
        failures++;
        $error("FAIL edge_count got=%0d exp=%0d", edges, exp_edges);
      end
    end
  endtask

  task automatic fill(input int kind, input logic [23:0] v);
    for (int r = 0; r < VD; r++)
      for (int c = 0; c < HD; c++)
        unique case (kind)
          0: img[r][c] = v;
          1: img[r][c] = (c >= 4) ? 24'hFFFFFF : 24'h0;
          2: img[r][c] = (r >= 3) ? v : 24'h0;
          3: img[r][c] = 24'($urandom);
          default: img[r][c] = {3{8'($urandom_range(0, 40))}};
        endcase
  endtask

  initial begin
    rst_n     = 1'b0;
    EN        = 1'b0;
    threshold = 8'd0;
    pre_vs    = 1'b0;
    pre_de    = 1'b0;
    pre_data  = 24'h0;
    model_en  = 1'b0;
    prev_vs   = 1'b0;
    thr_cur   = 0;
    fill(0, 24'h0);

    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0);
    checks++;
    assert ({post_vs, post_de, post_data} === 26'd0) else begin
      failures++;
      $error("FAIL reset_out got=%b/%b/%h exp=0",
             post_vs, post_de, post_data);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

    fill(0, 24'h808080);
    run_frame(0, 1, -1, 1, -1, 0);

    fill(1, 24'h0);
    run_frame(100, 1, -1, 1, -1, 8);

    fill(2, 24'h101010);
    run_frame(63, 1, -1, 1, -1, 12);
    run_frame(64, 1, -1, 1, -1, 0);

    fill(1, 24'h0);
    run_frame(100, 1, 3, 0, -1, 8);
    run_frame(100, 0, -1, 0, -1, 0);
    run_frame(100, 1, -1, 1, -1, 8);

    run_frame(100, 1, -1, 1, 2, 0);
    run_frame(100, 1, -1, 1, -1, 8);

    for (int f = 0; f < 4; f++) begin
      fill((f < 2) ? 3 : 4, 24'h0);
      run_frame($urandom_range(0, 255), 1'b1, -1, 1, -1, -1);
    end
    fill(4, 24'h0);
    run_frame($urandom_range(0, 60), 1'($urandom), -1, 1, -1, -1);

    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_edge.md
# sobel_edge

Streaming 3x3 Sobel edge detector that sits directly downstream of the `filter` stage in the DVP video pipeline. It consumes the smoothed 24-bit RGB pixel stream (`post_vs`/`post_de`/`post_data` of the filter) and converts it to 8-bit luma. It computes gradient magnitude over a line-buffered 3x3 window and emits a binary edge image in the same vs/de stream format. Fixed latency; frame geometry is preserved.

## Interface
- `IMG_HDISP`, 12'd1280, active pixels per line (line-buffer depth)
- `IMG_VDISP`, 12'd720, active lines per frame
- `clk`  in  1  pixel clock
- `rst_n`  in  1  reset, synchronous, active-low
- `EN`  in  1  edge detection enable (sampled at frame start)
- `threshold`  in  8  edge threshold on gradient magnitude
- `pre_vs`  in  1  input frame sync, active-high
- `pre_de`  in  1  input pixel valid
- `pre_data`  in  24  input pixel {R[23:16],G[15:8],B[7:0]}
- `post_vs`  out  1  output frame sync
- `post_de`  out  1  output pixel valid
- `post_data`  out  24  output pixel

## Operation
- Luma: Y = (77·R + 150·G + 29·B) >> 8, 16-bit intermediate, 8-bit result, no rounding.
- Column counter x: +1 per `pre_de` cycle; cleared on `pre_de` falling edge. Saturates at IMG_HDISP. Pixels beyond IMG_HDISP-1 are not written to line buffers and output 0.
- Row counter y: +1 on each `pre_de` falling edge; saturates at IMG_VDISP. x and y clear while `pre_vs`=1.
- `pre_vs`=1 has priority: `pre_de` is ignored while vs is high.
- Line buffers: two lines of 8-bit luma. Write at x, synchronous read at x. They form window rows r0 (y-2), r1 (y-1) and r2 (current). Each row has a 3-deep column shift register, giving p[row][col].
- Gx = (p02+2p12+p22) − (p00+2p10+p20); Gy = (p20+2p21+p22) − (p00+2p01+p02). Each is 11-bit signed.
- mag = |Gx|+|Gy|, 11-bit unsigned (max 2040). edge = mag > {3'b0,threshold}.
- The window is centred at (x−1,y−1) of the input. Output pixels with x<2 or y<2 are forced non-edge.
- Output without overlay: edge → 24'hFFFFFF, else 24'h000000.
- EN is latched into `en_q` on the `pre_vs` rising edge only. With `en_q`=0: counters are held cleared, `post_data`=0, and `post_vs`/`post_de` still track the delayed input. Mid-frame EN changes take effect at the next frame.
- Reset: all counters, pipeline registers and `en_q` clear to 0. Line-buffer RAM is not cleared; stale contents are masked by the y<2 rule.

## Timing
- Pipeline, 5 cycles:
  - S1: luma register.
  - S2: line-buffer read and window shift.
  - S3: Gx/Gy.
  - S4: abs and sum.
  - S5: compare and output register.
- `post_vs` and `post_de` are `pre_vs`/`pre_de` delayed exactly 5 cycles, independent of EN.
- `post_data` is valid only when `post_de`=1; it is 0 otherwise.
- All outputs are registered. Reset value of `post_vs`, `post_de` and `post_data` is 0. An output is 0 on the cycle after `rst_n` is sampled low.
- Throughput: 1 pixel per clock, no stall, no backpressure.

## Configuration
- `SOBEL_OVERLAY_EN` defined:
  - The original RGB is delayed 5 cycles alongside the pipeline.
  - Edge pixels output 24'hFF0000.
  - Non-edge and border pixels output the delayed original RGB.
  - With `en_q`=0, the output is the delayed original RGB.
- `SOBEL_OVERLAY_EN` undefined: binary white/black output as above. No RGB delay line is instantiated.

## Structure
- Shared package/header `vp_pkg`:
  - pixel width 24
  - luma coefficients 77/150/29
  - `SOBEL_LATENCY` = 5
  - overlay colour 24'hFF0000
- Sub-module `sobel_line_buffer`:
  - parameterised depth IMG_HDISP, width 8
  - one write port, one synchronous read port
  - instantiated twice, cascaded
- The top level contains counters, window, arithmetic, enable latch and delay lines.

## Test plan
Tests 1–5 use IMG_HDISP=8 and IMG_VDISP=6.

1. Uniform 24'h808080 frame, threshold 0 → mag 0, all `post_data`=0; `post_de` equals `pre_de` delayed by exactly 5 cycles.
2. Vertical step, columns 0–3 = 24'h000000 and columns 4–7 = 24'hFFFFFF, threshold 100, EN=1 → Y 0/255, |Gx|=1020. Output columns 4 and 5 are 24'hFFFFFF for rows 2–5; everything else is 0.
3. Horizontal step, rows 0–2 = 0 and rows 3–5 = 24'h101010 (Y=16, |Gy|=64). With threshold 63, output rows 3 and 4 (x≥2) are white. With threshold 64, all output is 0.
4. Vertical-step frame, EN 1→0 during row 3 → edges continue to the end of the frame. The next frame is all 0 while vs/de timing is unchanged. EN→1 resumes edges the frame after.
5. Vertical-step frame, `rst_n` low for 1 cycle at row 2 → next cycle all outputs 0 and counters cleared. The following frame (after `pre_vs`) reproduces test 2's result.
6. `SOBEL_OVERLAY_EN` defined, test 2 stimulus → columns 4 and 5 (rows 2–5) are 24'hFF0000; other pixels equal the input delayed 5 cycles.
